// File: rtl/mem_stage_bus_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_bus_if
// Purpose  : MEM-stage data-port bundle: CPU request side, BRAM port B and
//            the memory-mapped peripheral slots.
// Revision : 1.0 - initial release
// ============================================================================
interface mem_stage_bus_if #(
  parameter int RAM_AW   = 11,
  parameter int N_PERIPH = 4,
  parameter int PA_W     = 8
);
  logic                    cpu_req;
  logic                    cpu_we;
  logic [2:0]              cpu_funct3;
  logic [31:0]             cpu_addr;
  logic [31:0]             cpu_wdata;
  logic [31:0]             cpu_rdata;
  logic                    cpu_stall;
  logic                    cpu_fault;

  logic                    ram_en;
  logic [3:0]              ram_we;
  logic [RAM_AW-1:0]       ram_addr;
  logic [31:0]             ram_wdata;
  logic [31:0]             ram_rdata;

  logic [N_PERIPH-1:0]     per_req;
  logic                    per_we;
  logic [3:0]              per_be;
  logic [PA_W-1:0]         per_addr;
  logic [31:0]             per_wdata;
  logic [32*N_PERIPH-1:0]  per_rdata;
  logic [N_PERIPH-1:0]     per_ack;

  // master: the MEM-stage controller; slave: the core, BRAM and peripherals
  modport master (
    input  cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    output cpu_rdata, cpu_stall, cpu_fault,
    output ram_en, ram_we, ram_addr, ram_wdata,
    input  ram_rdata,
    output per_req, per_we, per_be, per_addr, per_wdata,
    input  per_rdata, per_ack
  );

  modport slave (
    output cpu_req, cpu_we, cpu_funct3, cpu_addr, cpu_wdata,
    input  cpu_rdata, cpu_stall, cpu_fault,
    input  ram_en, ram_we, ram_addr, ram_wdata,
    output ram_rdata,
    input  per_req, per_we, per_be, per_addr, per_wdata,
    output per_rdata, per_ack
  );
endinterface
`default_nettype wire

// File: rtl/mem_stage_bus.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_bus
// Purpose  : RV32 MEM-stage data-port controller: BRAM / peripheral decode,
//            byte lanes, load extension, req/ack stalling and fault pulses.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_bus #(
  parameter int          RAM_AW        = 11,
  parameter int          N_PERIPH      = 4,
  parameter logic [31:0] PERIPH_BASE   = 32'h1000_0000,
  parameter logic [31:0] PERIPH_STRIDE = 32'h1000_0000,
  parameter int          PA_W          = 8,
  parameter int          TIMEOUT       = 255
) (
  input  logic            clk,
  input  logic            rst,
  mem_stage_bus_if.master bus
);
  localparam int          c_SW        = (N_PERIPH > 1) ? $clog2(N_PERIPH) : 1;
  localparam logic [32:0] c_RAM_LIMIT = 33'(4) << RAM_AW;
  localparam logic [32:0] c_SLOT_SIZE = 33'(1) << PA_W;
  localparam logic [15:0] c_TMO_LAST  = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RAM_RD   = 2'd1,
    PER_WAIT = 2'd2
  } state_t;

  state_t              r_state;
  logic [N_PERIPH-1:0] r_per_req;
  logic                r_per_we;
  logic [3:0]          r_per_be;
  logic [PA_W-1:0]     r_per_addr;
  logic [31:0]         r_per_wdata;
  logic [c_SW-1:0]     r_slot;
  logic [2:0]          r_f3;
  logic [1:0]          r_lane;
  logic [31:0]         r_addr;
  logic                r_done;
  logic [15:0]         r_tmo;
  logic                r_fault;
  logic [31:0]         r_rdata;

  function automatic logic [31:0] f_extract(input logic [31:0] d,
                                            input logic [2:0]  f3,
                                            input logic [1:0]  lane);
    logic [31:0] sh;
    sh = d >> {lane, 3'b000};
    case (f3)
      3'd0:    return {{24{sh[7]}}, sh[7:0]};
      3'd1:    return {{16{sh[15]}}, sh[15:0]};
      3'd4:    return {24'd0, sh[7:0]};
      3'd5:    return {16'd0, sh[15:0]};
      default: return sh;
    endcase
  endfunction

  // Address decode
  logic [31:0]         w_off [N_PERIPH];
  logic [N_PERIPH-1:0] w_hit;
  logic [c_SW-1:0]     w_slot;
  logic                w_is_ram;

  for (genvar gi = 0; gi < N_PERIPH; gi++) begin : g_slot
    assign w_off[gi] = bus.cpu_addr - (PERIPH_BASE + 32'(gi) * PERIPH_STRIDE);
    assign w_hit[gi] = {1'b0, w_off[gi]} < c_SLOT_SIZE;
  end

  // Lowest-numbered slot wins if windows overlap
  always_comb begin
    w_slot = '0;
    for (int k = N_PERIPH - 1; k >= 0; k--) begin
      if (w_hit[k]) w_slot = c_SW'(k);
    end
  end

  assign w_is_ram = {1'b0, bus.cpu_addr} < c_RAM_LIMIT;

  logic [1:0]  w_size;
  logic [1:0]  w_lane;
  logic        w_mis;
  logic        w_unmapped;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;

  assign w_size     = bus.cpu_funct3[1:0];
  assign w_lane     = bus.cpu_addr[1:0];
  assign w_mis      = (bus.cpu_funct3 == 3'd3) || (bus.cpu_funct3[2] && bus.cpu_funct3[1]) ||
                      ((w_size == 2'd1) && bus.cpu_addr[0]) ||
                      ((w_size == 2'd2) && (w_lane != 2'd0));
  assign w_unmapped = !w_is_ram && !(|w_hit);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = bus.cpu_wdata;
    case (w_size)
      2'd0: begin
        w_be    = 4'b0001 << w_lane;
        w_wdata = {4{bus.cpu_wdata[7:0]}};
      end
      2'd1: begin
        w_be    = 4'b0011 << w_lane;
        w_wdata = {2{bus.cpu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // The held request right after a completion is the one just serviced
  logic w_issue, w_ok, w_ram_st, w_ram_ld, w_per_go, w_fault_now;
  logic w_ack, w_tmo;

  assign w_issue     = rst && (r_state == IDLE) && bus.cpu_req &&
                       !(r_done && (bus.cpu_addr == r_addr));
  assign w_ok        = w_issue && !w_mis && !w_unmapped;
  assign w_ram_st    = w_ok && w_is_ram && bus.cpu_we;
  assign w_ram_ld    = w_ok && w_is_ram && !bus.cpu_we;
  assign w_per_go    = w_ok && !w_is_ram;
  assign w_fault_now = w_issue && (w_mis || w_unmapped);
  assign w_ack       = (r_state == PER_WAIT) && (|(bus.per_ack & r_per_req));
  assign w_tmo       = (r_state == PER_WAIT) && !w_ack && (r_tmo == c_TMO_LAST);

  logic [31:0] w_per_rd;
  logic        w_complete;
  logic [31:0] w_cpl_data;

  assign w_per_rd = bus.per_rdata[32*r_slot +: 32];

  always_comb begin
    w_complete = 1'b0;
    w_cpl_data = 32'd0;
    if (r_state == RAM_RD) begin
      w_complete = 1'b1;
      w_cpl_data = f_extract(bus.ram_rdata, r_f3, r_lane);
    end else if (w_ack) begin
      w_complete = 1'b1;
      w_cpl_data = f_extract(w_per_rd, r_f3, r_lane);
    end else if (w_tmo || w_fault_now) begin
      w_complete = 1'b1;
    end
  end

  assign bus.ram_en    = w_ram_st || w_ram_ld;
  assign bus.ram_we    = w_ram_st ? w_be : 4'b0000;
  assign bus.ram_addr  = bus.cpu_addr[RAM_AW+1:2];
  assign bus.ram_wdata = w_wdata;
  assign bus.cpu_stall = w_ram_ld || w_per_go ||
                         ((r_state == PER_WAIT) && !w_ack && !w_tmo);
  assign bus.cpu_rdata = w_complete ? w_cpl_data : r_rdata;
  assign bus.cpu_fault = r_fault;
  assign bus.per_req   = r_per_req;
  assign bus.per_we    = r_per_we;
  assign bus.per_be    = r_per_be;
  assign bus.per_addr  = r_per_addr;
  assign bus.per_wdata = r_per_wdata;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_per_req   <= '0;
      r_per_we    <= 1'b0;
      r_per_be    <= 4'd0;
      r_per_addr  <= '0;
      r_per_wdata <= 32'd0;
      r_slot      <= '0;
      r_f3        <= 3'd0;
      r_lane      <= 2'd0;
      r_addr      <= 32'd0;
      r_done      <= 1'b0;
      r_tmo       <= 16'd0;
      r_fault     <= 1'b0;
      r_rdata     <= 32'd0;
    end else begin
      r_fault <= 1'b0;
      r_done  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ram_ld) begin
            r_state <= RAM_RD;
            r_f3    <= bus.cpu_funct3;
            r_lane  <= w_lane;
            r_addr  <= bus.cpu_addr;
          end else if (w_per_go) begin
            r_state     <= PER_WAIT;
            r_per_req   <= N_PERIPH'(1) << w_slot;
            r_slot      <= w_slot;
            r_per_we    <= bus.cpu_we;
            r_per_be    <= w_be;
            r_per_addr  <= w_off[w_slot][PA_W-1:0];
            r_per_wdata <= w_wdata;
            r_f3        <= bus.cpu_funct3;
            r_lane      <= w_lane;
            r_addr      <= bus.cpu_addr;
            r_tmo       <= 16'd0;
          end else if (w_fault_now) begin
            r_fault <= 1'b1;
            r_rdata <= 32'd0;
          end
        end
        RAM_RD: begin
          r_rdata <= w_cpl_data;
          r_done  <= 1'b1;
          r_state <= IDLE;
        end
        PER_WAIT: begin
          if (w_ack) begin
            r_per_req <= '0;
            r_rdata   <= w_cpl_data;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end else if (w_tmo) begin
            r_per_req <= '0;
            r_fault   <= 1'b1;
            r_rdata   <= 32'd0;
            r_done    <= 1'b1;
            r_state   <= IDLE;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
`default_nettype wire
